// File: rtl/pe_skew_feeder_pkg.sv
// Shared types for the systolic-array operand skew feeder.
package pe_skew_feeder_pkg;

  typedef enum logic [1:0] {
    FEED_IDLE   = 2'd0,
    FEED_STREAM = 2'd1,
    FEED_DRAIN  = 2'd2
  } feeder_state_e;

  localparam int FEEDER_LANES_DEF = 4;

endpackage

// File: rtl/pe_skew_feeder_skew_delay_line.sv
// One lane of the diagonal skew: a DEPTH-stage {valid, data} shift register.
// PE_SKEW_FEEDER_ZERO_GATE_EN forces dout to zero whenever vout is low.
module skew_delay_line #(
  parameter int DEPTH  = 1,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              vin,
  input  logic [DATA_W-1:0] din,
  output logic              vout,
  output logic [DATA_W-1:0] dout
);

  logic [DEPTH-1:0]  v_r;
  logic [DATA_W-1:0] d_r [DEPTH];

  // Shift valid and data one stage per cycle; no stall path exists.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      v_r <= {DEPTH{1'b0}};
      for (int k = 0; k < DEPTH; k++) begin
        d_r[k] <= {DATA_W{1'b0}};
      end
    end else begin
      v_r[0] <= vin;
      d_r[0] <= din;
      for (int k = 1; k < DEPTH; k++) begin
        v_r[k] <= v_r[k-1];
        d_r[k] <= d_r[k-1];
      end
    end
  end

  assign vout = v_r[DEPTH-1];

`ifdef PE_SKEW_FEEDER_ZERO_GATE_EN
  // Quiet idle PE inputs: bubbles present zero data.
  always_comb begin
    if (v_r[DEPTH-1]) begin
      dout = d_r[DEPTH-1];
    end else begin
      dout = {DATA_W{1'b0}};
    end
  end
`else
  assign dout = d_r[DEPTH-1];
`endif

endmodule

// File: rtl/pe_skew_feeder.sv
// Operand feeder for a pe_cell row/column: accepts LANES-wide beats, skews lane i by i cycles,
// drains after the last beat of a tile and pulses tile_done. Optional macro: PE_SKEW_FEEDER_ZERO_GATE_EN.
module pe_skew_feeder
  import pe_skew_feeder_pkg::*;
#(
  parameter int LANES  = FEEDER_LANES_DEF,
  parameter int DATA_W = 32,
  parameter int K_MAX  = 16
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*DATA_W-1:0] in_data,
  input  logic                    in_last,
  output logic [LANES-1:0]        out_valid,
  output logic [LANES*DATA_W-1:0] out_data,
  output logic                    busy,
  output logic                    tile_done,
  output logic                    err_overlong
);

  localparam int CNT_W = $clog2(K_MAX + 1);
  localparam int DRN_W = $clog2(LANES);
  localparam logic [CNT_W-1:0] K_MAX_C  = CNT_W'(K_MAX);
  localparam logic [DRN_W-1:0] DRAIN_LD = DRN_W'(LANES - 1);

  feeder_state_e    state_r, state_s;
  logic [CNT_W-1:0] beat_r, beat_s;
  logic [DRN_W-1:0] drain_r, drain_s;
  logic             err_r, err_s;
  logic             tile_done_r, tile_done_s;
  logic             accept_s;

  assign in_ready     = (state_r != FEED_DRAIN);
  assign busy         = (state_r != FEED_IDLE);
  assign accept_s     = in_valid && in_ready;
  assign tile_done    = tile_done_r;
  assign err_overlong = err_r;

  // Control state, beat/drain counters and registered status flags.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_r     <= FEED_IDLE;
      beat_r      <= {CNT_W{1'b0}};
      drain_r     <= {DRN_W{1'b0}};
      err_r       <= 1'b0;
      tile_done_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      beat_r      <= beat_s;
      drain_r     <= drain_s;
      err_r       <= err_s;
      tile_done_r <= tile_done_s;
    end
  end

  // Next-state decode; tile_done is registered one cycle ahead so it lands as drain reaches 0.
  always_comb begin
    state_s     = state_r;
    beat_s      = beat_r;
    drain_s     = drain_r;
    err_s       = err_r;
    tile_done_s = 1'b0;
    case (state_r)
      FEED_IDLE: begin
        if (accept_s) begin
          if (in_last) begin
            state_s = FEED_DRAIN;
            drain_s = DRAIN_LD;
            beat_s  = {CNT_W{1'b0}};
          end else begin
            state_s = FEED_STREAM;
            beat_s  = CNT_W'(1);
          end
        end else begin
          state_s = FEED_IDLE;
        end
      end
      FEED_STREAM: begin
        if (accept_s) begin
          if (beat_r == K_MAX_C) begin
            err_s = 1'b1;
          end else begin
            err_s = err_r;
          end
          if (in_last) begin
            state_s = FEED_DRAIN;
            drain_s = DRAIN_LD;
            beat_s  = {CNT_W{1'b0}};
          end else if (beat_r != K_MAX_C) begin
            beat_s = beat_r + CNT_W'(1);
          end else begin
            beat_s = beat_r;
          end
        end else begin
          state_s = FEED_STREAM;
        end
      end
      FEED_DRAIN: begin
        if (drain_r == {DRN_W{1'b0}}) begin
          state_s = FEED_IDLE;
        end else begin
          drain_s = drain_r - DRN_W'(1);
          if (drain_r == DRN_W'(1)) begin
            tile_done_s = 1'b1;
          end else begin
            tile_done_s = 1'b0;
          end
        end
      end
      default: begin
        state_s = FEED_IDLE;
      end
    endcase
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    skew_delay_line #(
      .DEPTH  (i + 1),
      .DATA_W (DATA_W)
    ) u_line (
      .clk  (clk),
      .rstn (rstn),
      .vin  (accept_s),
      .din  (in_data[i*DATA_W +: DATA_W]),
      .vout (out_valid[i]),
      .dout (out_data[i*DATA_W +: DATA_W])
    );
  end

endmodule
